l2_tlb_ram_arbiter: RTL

- Single owner of the single-port L2 TLB data RAM (512x45, one RW port, 1-cycle registered read).
- Arbitrates between three sources: PTW lookup reads, refill writes, and a full-array flush sweep.
- Drives the RAM port directly and returns read data with fixed latency. Sits between the L2 TLB control logic and the RAM macro.

---
 rtl/l2_tlb_ram_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/l2_tlb_ram_arbiter.sv
// Single owner of the single-port L2 TLB data RAM: arbitrates PTW lookup reads,
// refill writes and a full-array flush sweep onto one RW port.
module l2_tlb_ram_arbiter #(
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned DW           = 45,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  // lookup port
  input  logic          lkp_valid,
  output logic          lkp_ready,
  input  logic [AW-1:0] lkp_addr,
  output logic          lkp_resp_valid,
  output logic [DW-1:0] lkp_resp_data,
  // refill port
  input  logic          ref_valid,
  output logic          ref_ready,
  input  logic [AW-1:0] ref_addr,
  input  logic [DW-1:0] ref_data,
  // flush control
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          flush_done,
  // RAM macro port
  output logic [AW-1:0] ram_addr,
  output logic          ram_en,
  output logic          ram_wmode,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          flush_pending_q, flush_pending_d;
  logic          resp_valid_q;
  logic          lkp_grant, ref_grant;

  always_comb begin
    state_d         = state_q;
    sweep_cnt_d     = sweep_cnt_q;
    starve_d        = starve_q;
    flush_pending_d = flush_pending_q;
    lkp_grant       = 1'b0;
    ref_grant       = 1'b0;
    flush_busy      = 1'b0;
    flush_done      = 1'b0;
    ram_en          = 1'b0;
    ram_wmode       = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;

    case (state_q)
      StIdle: begin
        if (flush_req || flush_pending_q) begin
          // Flush pre-empts arbitration: nothing is granted in this cycle.
          state_d         = StSweep;
          sweep_cnt_d     = '0;
          flush_pending_d = 1'b0;
        end else if (reset_n) begin
          // Grants are gated by reset so the RAM port stays quiet while it is held.
          if (ref_valid && !(lkp_valid && (starve_q == StarveMax))) begin
            ref_grant = 1'b1;
          end else if (lkp_valid) begin
            lkp_grant = 1'b1;
          end

          if (!lkp_valid || lkp_grant) begin
            starve_d = '0;
          end else if (ref_grant) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end

      StSweep: begin
        flush_busy = 1'b1;
        ram_en     = 1'b1;
        ram_wmode  = 1'b1;
        ram_addr   = sweep_cnt_q;
        if (flush_req) begin
          flush_pending_d = 1'b1;
        end
        if (sweep_cnt_q == LastAddr) begin
          state_d = StDone;
        end else begin
          sweep_cnt_d = sweep_cnt_q + AW'(1);
        end
      end

      StDone: begin
        flush_busy = 1'b1;
        flush_done = 1'b1;
        if (flush_req) begin
          flush_pending_d = 1'b1;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (ref_grant) begin
      ram_en    = 1'b1;
      ram_wmode = 1'b1;
      ram_addr  = ref_addr;
      ram_wdata = ref_data;
    end else if (lkp_grant) begin
      ram_en    = 1'b1;
      ram_wmode = 1'b0;
      ram_addr  = lkp_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      sweep_cnt_q     <= '0;
      starve_q        <= '0;
      flush_pending_q <= 1'b0;
      resp_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      sweep_cnt_q     <= sweep_cnt_d;
      starve_q        <= starve_d;
      flush_pending_q <= flush_pending_d;
      resp_valid_q    <= lkp_grant;
    end
  end

  assign lkp_ready      = lkp_grant;
  assign ref_ready      = ref_grant;
  assign lkp_resp_valid = resp_valid_q;
  // The RAM read register already provides the one-cycle latency.
  assign lkp_resp_data  = ram_rdata;

endmodule
